// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The master side drives the PLL lock input and the retry request; the
// slave side (the sequencer) drives the PLL reset, system reset and status.
interface pll_lock_sequencer_if;
  logic       LOCK;
  logic       RETRY_REQ;
  logic       PLL_RESETB;
  logic       SYS_RST;
  logic       READY;
  logic       FAULT;
  logic [1:0] RETRY_CNT;
  logic [7:0] LOSS_CNT;

  modport master (
    output LOCK, RETRY_REQ,
    input  PLL_RESETB, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT
  );

  modport slave (
    input  LOCK, RETRY_REQ,
    output PLL_RESETB, SYS_RST, READY, FAULT, RETRY_CNT, LOSS_CNT
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer running on the 12 MHz reference clock.
// Pulses the PLL's active-low reset, waits for a stable synchronised LOCK,
// then releases the system reset. Handles lock timeout with bounded retry,
// lock glitches during qualification and lock loss while running.
// All outputs are registered; the 48 MHz domain must re-synchronise SYS_RST.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 12000,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  pll_lock_sequencer_if.slave  bus
);

  localparam logic [2:0] ST_HOLD      = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FAIL      = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic [1:0]       sync_q;
  logic             lock_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [7:0]       loss_q, loss_d;
  logic             pll_resetb_q, pll_resetb_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;

  assign lock_s = sync_q[1];

  // Two-flop synchroniser for the PLL LOCK output, which is asynchronous to CLK.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], bus.LOCK};
  end

  // Next-state, counter, retry/loss bookkeeping and registered output decode.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned (which would infer a latch); combinational blocks use
    // blocking '=', the flop blocks below use non-blocking '<='.
    state_d = state_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // A lock arriving on the timeout cycle still wins.
        if (lock_s) begin
          state_d = ST_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q == RETRY_LIMIT) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_HOLD;
            retry_d = retry_q + 2'd1;
          end
        end
      end
      ST_STABLE: begin
        // Any dropout restarts qualification with a fresh timeout window.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          retry_d = 2'd0;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_HOLD;
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
        end
      end
      ST_FAIL: begin
        if (bus.RETRY_REQ) begin
          state_d = ST_HOLD;
          retry_d = 2'd0;
        end
      end
      default: state_d = ST_HOLD;
    endcase

    // Shared cycle counter: restarts on every state change, idle in RUN/FAIL.
    if (state_d != state_q || state_q == ST_RUN || state_q == ST_FAIL)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    // Outputs are decoded from the next state so they change on the same
    // edge as the state itself.
    pll_resetb_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_STABLE) ||
                   (state_d == ST_RUN);
    sys_rst_d    = (state_d != ST_RUN);
    ready_d      = (state_d == ST_RUN);
    fault_d      = (state_d == ST_FAIL);
  end

  // State, counters and registered outputs; RESET forces the safe values at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_HOLD;
      cnt_q        <= '0;
      retry_q      <= 2'd0;
      loss_q       <= 8'd0;
      pll_resetb_q <= 1'b0;
      sys_rst_q    <= 1'b1;
      ready_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= pll_resetb_d;
      sys_rst_q    <= sys_rst_d;
      ready_q      <= ready_d;
      fault_q      <= fault_d;
    end
  end

  assign bus.PLL_RESETB = pll_resetb_q;
  assign bus.SYS_RST    = sys_rst_q;
  assign bus.READY      = ready_q;
  assign bus.FAULT      = fault_q;
  assign bus.RETRY_CNT  = retry_q;
  assign bus.LOSS_CNT   = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with a deadline-based reference model
// checked every cycle, plus hand-computed latency and count expectations.
module tb_pll_lock_sequencer;

  localparam int RST_C = 4;
  localparam int LS    = 8;
  localparam int TO    = 32;
  localparam int MAXR  = 2;

  localparam int S_PLLRB  = 0;
  localparam int S_SYSRST = 1;
  localparam int S_READY  = 2;
  localparam int S_FAULT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RST_CYCLES  (RST_C),
    .LOCK_STABLE (LS),
    .LOCK_TIMEOUT(TO),
    .MAX_RETRIES (MAXR),
    .CNT_W       (16)
  ) dut (
    .CLK  (clk),
    .RESET(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each phase has an absolute deadline edge; transitions follow the
  // sequencing rules directly in terms of edges elapsed.
  typedef enum {P_HOLD, P_WAIT, P_STABLE, P_RUN, P_FAIL} phase_t;

  phase_t ph;
  int     cyc = 0;        // rising edges seen outside reset
  int     deadline;
  int     m_retries;
  int     m_losses;
  bit     lock_pipe[$];   // LOCK as sampled on the last two edges

  function automatic void enter(phase_t p, int dur);
    ph       = p;
    deadline = cyc + dur;
  endfunction

  function automatic void m_reset();
    ph        = P_HOLD;
    deadline  = cyc + RST_C;
    m_retries = 0;
    m_losses  = 0;
    lock_pipe = '{1'b0, 1'b0};
  endfunction

  function automatic void m_step(bit lock_in, bit retry_req);
    bit s;
    s = lock_pipe[0];
    void'(lock_pipe.pop_front());
    lock_pipe.push_back(lock_in);
    case (ph)
      P_HOLD:   if (cyc == deadline) enter(P_WAIT, TO);
      P_WAIT: begin
        if (s) enter(P_STABLE, LS);
        else if (cyc == deadline) begin
          if (m_retries == MAXR) enter(P_FAIL, 0);
          else begin
            m_retries++;
            enter(P_HOLD, RST_C);
          end
        end
      end
      P_STABLE: begin
        if (!s) enter(P_WAIT, TO);
        else if (cyc == deadline) begin
          m_retries = 0;
          enter(P_RUN, 0);
        end
      end
      P_RUN: begin
        if (!s) begin
          if (m_losses < 255) m_losses++;
          enter(P_HOLD, RST_C);
        end
      end
      P_FAIL: begin
        if (retry_req) begin
          m_retries = 0;
          enter(P_HOLD, RST_C);
        end
      end
      default: ;
    endcase
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        cyc++;
        m_step(bus.LOCK, bus.RETRY_REQ);
      end
    end
  end

  // Compare every output against the model just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("pll_resetb", bus.PLL_RESETB, (ph == P_WAIT || ph == P_STABLE || ph == P_RUN));
      check("sys_rst",    bus.SYS_RST,    (ph != P_RUN));
      check("ready",      bus.READY,      (ph == P_RUN));
      check("fault",      bus.FAULT,      (ph == P_FAIL));
      check("retry_cnt",  bus.RETRY_CNT,  m_retries);
      check("loss_cnt",   bus.LOSS_CNT,   m_losses);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic sig(int sel);
    case (sel)
      S_PLLRB:  return bus.PLL_RESETB;
      S_SYSRST: return bus.SYS_RST;
      S_READY:  return bus.READY;
      default:  return bus.FAULT;
    endcase
  endfunction

  // Waits (bounded) until the selected output takes 'val'; returns the edge index.
  task automatic wait_sig(input int sel, input logic val, input int budget,
                          input string name, output int at);
    logic found;
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (sig(sel) === val) begin
        found = 1'b1;
        at    = cyc;
        break;
      end
    end
    check({name, " reached"}, found, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t, a, at, at2, at3, c0;
    bus.LOCK      = 1'b0;
    bus.RETRY_REQ = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset pll_resetb", bus.PLL_RESETB, 1'b0);
    check("reset sys_rst",    bus.SYS_RST,    1'b1);
    check("reset ready",      bus.READY,      1'b0);
    check("reset fault",      bus.FAULT,      1'b0);
    check("reset retry_cnt",  bus.RETRY_CNT,  2'd0);
    check("reset loss_cnt",   bus.LOSS_CNT,   8'd0);
    rst = 1'b0;
    c0  = cyc;

    // Nominal lock
    wait_sig(S_PLLRB, 1'b1, 20, "hold release", at);
    check("hold length", at - c0, RST_C);
    repeat (10) @(negedge clk);
    t = cyc;
    bus.LOCK = 1'b1;
    wait_sig(S_READY, 1'b1, 40, "nominal ready", at);
    check("nominal latency", at - t, 11);
    check("nominal sys_rst", bus.SYS_RST, 1'b0);
    check("nominal retry_cnt", bus.RETRY_CNT, 2'd0);

    // RETRY_REQ outside FAIL is ignored
    @(negedge clk); bus.RETRY_REQ = 1'b1;
    @(negedge clk); bus.RETRY_REQ = 1'b0;
    @(negedge clk);
    check("retry_req ignored in run", bus.READY, 1'b1);

    // Lock loss in RUN
    t = cyc;
    bus.LOCK = 1'b0;
    wait_sig(S_SYSRST, 1'b1, 10, "loss sys_rst", at);
    check("loss latency", at - t, 3);
    check("loss ready", bus.READY, 1'b0);
    check("loss count 1", bus.LOSS_CNT, 8'd1);

    // Glitchy lock: 5 good STABLE cycles, 1-cycle dropout, then clean
    wait_sig(S_PLLRB, 1'b1, 20, "glitch wait_lock", at);
    @(negedge clk);
    t = cyc;
    bus.LOCK = 1'b1;
    repeat (6) @(negedge clk);
    bus.LOCK = 1'b0;
    @(negedge clk);
    bus.LOCK = 1'b1;
    wait_sig(S_READY, 1'b1, 40, "glitch ready", at);
    check("glitch latency", at - t, 18);

    // Timeout retries into FAIL
    @(negedge clk);
    bus.LOCK = 1'b0;
    wait_sig(S_SYSRST, 1'b1, 10, "timeout loss", at);
    wait_sig(S_PLLRB, 1'b1, 20, "timeout first wait", a);
    wait_sig(S_PLLRB, 1'b0, 60, "timeout 1", at);
    check("timeout 1 window", at - a, TO);
    check("retry_cnt 1", bus.RETRY_CNT, 2'd1);
    wait_sig(S_PLLRB, 1'b1, 20, "retry 1 release", at2);
    check("retry pulse width", at2 - at, RST_C);
    wait_sig(S_PLLRB, 1'b0, 60, "timeout 2", at3);
    check("retry period", at3 - at, TO + RST_C);
    check("retry_cnt 2", bus.RETRY_CNT, 2'd2);
    wait_sig(S_FAULT, 1'b1, 60, "fail entry", at);
    check("fail period", at - at3, TO + RST_C);
    check("fail pll_resetb", bus.PLL_RESETB, 1'b0);
    check("fail sys_rst", bus.SYS_RST, 1'b1);

    // FAIL recovery
    repeat (5) @(negedge clk);
    t = cyc;
    bus.RETRY_REQ = 1'b1;
    @(negedge clk);
    bus.RETRY_REQ = 1'b0;
    bus.LOCK      = 1'b1;
    check("recover fault", bus.FAULT, 1'b0);
    check("recover retry_cnt", bus.RETRY_CNT, 2'd0);
    check("recover pll_resetb", bus.PLL_RESETB, 1'b0);
    wait_sig(S_PLLRB, 1'b1, 20, "recover release", at2);
    check("recover hold length", at2 - t, 1 + RST_C);
    wait_sig(S_READY, 1'b1, 40, "recover ready", at3);
    check("recover latency", at3 - t, 1 + RST_C + 1 + LS);

    // Async reset while in STABLE
    @(negedge clk);
    bus.LOCK = 1'b0;
    wait_sig(S_SYSRST, 1'b1, 10, "pre-reset loss", at);
    wait_sig(S_PLLRB, 1'b1, 20, "pre-reset wait_lock", at);
    @(negedge clk);
    bus.LOCK = 1'b1;
    repeat (5) @(negedge clk);
    check("stable pll_resetb", bus.PLL_RESETB, 1'b1);
    check("stable ready", bus.READY, 1'b0);
    check("loss count 3", bus.LOSS_CNT, 8'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async pll_resetb", bus.PLL_RESETB, 1'b0);
    check("async sys_rst", bus.SYS_RST, 1'b1);
    check("async retry_cnt", bus.RETRY_CNT, 2'd0);
    check("async loss_cnt", bus.LOSS_CNT, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // LOSS_CNT saturation over 256 lock losses
    for (int i = 0; i < 256; i++) begin
      wait_sig(S_READY, 1'b1, 40, "sat ready", at);
      @(negedge clk);
      bus.LOCK = 1'b0;
      wait_sig(S_SYSRST, 1'b1, 10, "sat loss", at);
      @(negedge clk);
      bus.LOCK = 1'b1;
      if (i == 254) check("loss count 255", bus.LOSS_CNT, 8'd255);
    end
    check("loss count saturated", bus.LOSS_CNT, 8'd255);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
